// File: rtl/presc.sv
`timescale 1ns/1ps
// presc: fixed-ratio even clock divider with a 50% duty, flop-driven output.
// The half-period counter wraps on an explicit compare, so oversizing CNT_W_P never changes the ratio.
module presc #(
  parameter int DIV_P   = 16,
  parameter int CNT_W_P = ((DIV_P / 2) > 1) ? $clog2(DIV_P / 2) : 1
) (
  input  logic clk_in_p,
  input  logic rst_n_p,
  output logic clk_out_p
);
  localparam int HALF = DIV_P / 2;
  localparam logic [CNT_W_P-1:0] LAST = CNT_W_P'(HALF - 1);

  if ((DIV_P < 2) || ((DIV_P % 2) != 0)) begin : g_bad_div
    $fatal(1, "presc: DIV_P=%0d must be an even integer >= 2", DIV_P);
  end

  logic [CNT_W_P-1:0] cnt_q, cnt_d;
  logic               clk_q, clk_d;
  logic               wrap;

  assign wrap = (cnt_q == LAST);

  always_comb begin
    cnt_d = wrap ? '0 : cnt_q + CNT_W_P'(1);
    clk_d = wrap ? ~clk_q : clk_q;
  end

  always_ff @(posedge clk_in_p or negedge rst_n_p) begin
    if (!rst_n_p) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
    end
  end

  assign clk_out_p = clk_q;
endmodule

// File: tb/tb_presc.sv
`timescale 1ns/1ps
// Bench for presc: DIV_P = 16, 6 and 2 side by side on one clock and reset,
// checked against an edge-count model, a hand-derived table and phase-length measurements.
module tb_presc;
  logic clk_in = 1'b0;
  logic rst_n  = 1'b1;
  logic o16, o6, o2;
  int   tests = 0;
  int   fails = 0;
  int   n     = 0;   // rising edges of clk_in seen since the last reset release

  presc #(.DIV_P(16)) u16 (.clk_in_p(clk_in), .rst_n_p(rst_n), .clk_out_p(o16));
  presc #(.DIV_P(6))  u6  (.clk_in_p(clk_in), .rst_n_p(rst_n), .clk_out_p(o6));
  presc #(.DIV_P(2))  u2  (.clk_in_p(clk_in), .rst_n_p(rst_n), .clk_out_p(o2));

  always #1 clk_in = ~clk_in;

  always @(posedge clk_in or negedge rst_n)
    if (!rst_n) n <= 0;
    else        n <= n + 1;

  // Output after `edges` rising edges: it has toggled floor(edges / (div/2)) times from 0.
  function automatic logic ref_out(int div, int edges, logic rn);
    if (!rn) return 1'b0;
    return ((edges / (div / 2)) % 2) != 0;
  endfunction

  task automatic chk(string name, logic act, logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (edge %0d)", name, act, exp, n);
    end
  endtask

  task automatic chk_int(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_model(string tag);
    chk({tag, "_16"}, o16, ref_out(16, n, rst_n));
    chk({tag, "_6"},  o6,  ref_out(6,  n, rst_n));
    chk({tag, "_2"},  o2,  ref_out(2,  n, rst_n));
  endtask

  typedef struct {
    int   k;
    logic e16;
    logic e6;
    logic e2;
  } vec_t;

  vec_t vt[11];

  initial begin
    logic [2:0] prev;
    logic [2:0] cur;
    int         trans[3];
    int         last[3];
    int         half[3];
    int         first_rise;
    int         first_fall;
    int         ti;
    int         rise_t;
    int         prev_rise_t;

    vt[0]  = '{1,  1'b0, 1'b0, 1'b1};
    vt[1]  = '{2,  1'b0, 1'b0, 1'b0};
    vt[2]  = '{3,  1'b0, 1'b1, 1'b1};
    vt[3]  = '{6,  1'b0, 1'b0, 1'b0};
    vt[4]  = '{7,  1'b0, 1'b0, 1'b1};
    vt[5]  = '{8,  1'b1, 1'b0, 1'b0};
    vt[6]  = '{9,  1'b1, 1'b1, 1'b1};
    vt[7]  = '{12, 1'b1, 1'b0, 1'b0};
    vt[8]  = '{15, 1'b1, 1'b1, 1'b1};
    vt[9]  = '{16, 1'b0, 1'b1, 1'b0};
    vt[10] = '{24, 1'b1, 1'b0, 1'b0};
    half[0] = 8; half[1] = 3; half[2] = 1;

    // Reset for two full cycles, asserted away from any clock edge
    #0.3 rst_n = 1'b0;
    #0.2;
    chk("rst_async_16", o16, 1'b0);
    chk("rst_async_6",  o6,  1'b0);
    chk("rst_async_2",  o2,  1'b0);
    repeat (2) @(negedge clk_in);
    chk("rst_hold_16", o16, 1'b0);
    chk("rst_hold_6",  o6,  1'b0);
    chk("rst_hold_2",  o2,  1'b0);
    #0.5 rst_n = 1'b1;

    // Steady run: 256 edges, table, model, transitions and phase lengths
    prev = 3'b000;
    for (int i = 0; i < 3; i++) begin trans[i] = 0; last[i] = 0; end
    first_rise = -1; first_fall = -1; ti = 0;
    rise_t = 0; prev_rise_t = 0;
    for (int c = 0; c < 256; c++) begin
      @(negedge clk_in);
      chk_model("steady");
      if (ti < 11 && n == vt[ti].k) begin
        chk($sformatf("tbl%0d_16", vt[ti].k), o16, vt[ti].e16);
        chk($sformatf("tbl%0d_6",  vt[ti].k), o6,  vt[ti].e6);
        chk($sformatf("tbl%0d_2",  vt[ti].k), o2,  vt[ti].e2);
        ti++;
      end
      cur = {o2, o6, o16};
      for (int i = 0; i < 3; i++) begin
        if (cur[i] !== prev[i]) begin
          trans[i]++;
          if (trans[i] > 1)
            chk_int($sformatf("phase_len_div%0d", 2 * half[i]), n - last[i], half[i]);
          last[i] = n;
        end
      end
      if (o16 && !prev[0]) begin
        prev_rise_t = rise_t;
        rise_t = int'($time);
        if (first_rise < 0) first_rise = n;
        else chk_int("period16_time", rise_t - prev_rise_t, 32);
      end
      if (!o16 && prev[0] && first_fall < 0) first_fall = n;
      prev = cur;
    end
    chk_int("table_applied", ti, 11);
    chk_int("first_rise16", first_rise, 8);
    chk_int("first_fall16", first_fall, 16);
    chk_int("trans16", trans[0], 32);
    chk_int("trans6",  trans[1], 85);
    chk_int("trans2",  trans[2], 256);

    // Mid-period reset with cnt = 5 and the DIV 16 output high
    for (int c = 0; c < 20 && (n % 16) != 13; c++) @(negedge clk_in);
    chk_int("midrst_pos", n % 16, 13);
    chk("midrst_pre16", o16, 1'b1);
    #0.5 rst_n = 1'b0;
    #0.2;
    chk("midrst_async16", o16, 1'b0);
    chk("midrst_async6",  o6,  1'b0);
    chk("midrst_async2",  o2,  1'b0);
    repeat (2) @(negedge clk_in);
    #0.5 rst_n = 1'b1;
    repeat (7) @(negedge clk_in);
    chk("midrst_edge7_16", o16, 1'b0);
    @(negedge clk_in);
    chk("midrst_edge8_16", o16, 1'b1);

    // Random run lengths and reset pulses against the model
    for (int it = 0; it < 20; it++) begin
      int run;
      run = int'($urandom_range(1, 40));
      repeat (run) begin
        @(negedge clk_in);
        chk_model("rand");
      end
      #(real'($urandom_range(1, 9)) / 10.0);
      rst_n = 1'b0;
      #0.05;
      chk_model("rand_rst");
      repeat (int'($urandom_range(1, 3))) @(negedge clk_in);
      chk_model("rand_hold");
      #0.5 rst_n = 1'b1;
    end
    repeat (20) begin
      @(negedge clk_in);
      chk_model("tail");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
